// File: rtl/lru_resolver_pkg.sv
// Shared types for the LRU resolve stage: tagged keys, lookup values, results
// and history entries.
package lru_resolver_pkg;
  localparam int KEY_BITS = 8;
  localparam int VAL_BITS = 16;

  typedef logic [KEY_BITS-1:0] key_t;
  typedef logic [VAL_BITS-1:0] val_t;

  typedef struct packed {
    key_t key;
    logic last;
    logic hit;
  } ext_t;

  typedef struct packed {
    key_t key;
    val_t val;
    logic last;
  } res_t;

  typedef struct packed {
    key_t key;
    val_t val;
  } hist_t;

  localparam int EXT_BITS = $bits(ext_t);
endpackage

// File: rtl/lru_resolver_pend.sv
// Pending-entry FIFO: holds accepted tagged keys until their value is resolved.
module pend_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] head,
  output logic             full,
  output logic             empty
);
  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [AW:0]      count;

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= push_data;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  assign head  = mem[rd_ptr];
  assign full  = (count == (AW+1)'(DEPTH));
  assign empty = (count == '0);
endmodule

// File: rtl/lru_resolver.sv
// Resolves hit-tagged keys: misses go to the lookup unit, hits are served from
// a short history of recent results; results leave strictly in arrival order.
module lru_resolver
  import lru_resolver_pkg::*;
#(
  parameter int CACHE_DEPTH = 8,
  parameter int PEND_DEPTH  = 16
) (
  input  logic                aclk,
  input  logic                areset,
  input  logic                s_meta_valid,
  output logic                s_meta_ready,
  input  logic [KEY_BITS-1:0] s_meta_key,
  input  logic                s_meta_last,
  input  logic                s_meta_hit,
  output logic                m_req_valid,
  input  logic                m_req_ready,
  output logic [KEY_BITS-1:0] m_req_key,
  input  logic                s_rsp_valid,
  output logic                s_rsp_ready,
  input  logic [VAL_BITS-1:0] s_rsp_val,
  output logic                m_res_valid,
  input  logic                m_res_ready,
  output logic [KEY_BITS-1:0] m_res_key,
  output logic [VAL_BITS-1:0] m_res_val,
  output logic                m_res_last,
  output logic [31:0]         hit_cnt,
  output logic [31:0]         miss_cnt,
  output logic                err_nomatch
);
  localparam int HIST_N = CACHE_DEPTH - 1;

  // All streams use valid/ready: a transfer happens on a rising edge where
  // both are high; a source holds valid and data stable until it transfers.

  ext_t  in_ext;
  ext_t  head;
  logic  pend_full;
  logic  pend_empty;
  logic  push;
  logic  fire;
  hist_t hist [HIST_N];
  logic [HIST_N-1:0] hist_vld;
  logic  match_found;
  val_t  match_val;
  val_t  res_val;
  res_t  res_q;

  assign in_ext       = '{key: s_meta_key, last: s_meta_last, hit: s_meta_hit};
  assign m_req_valid  = s_meta_valid & ~s_meta_hit & ~pend_full;
  assign m_req_key    = s_meta_key;
  assign s_meta_ready = ~pend_full & (s_meta_hit | m_req_ready);
  assign push         = s_meta_valid & s_meta_ready;

  pend_fifo #(
    .WIDTH(EXT_BITS),
    .DEPTH(PEND_DEPTH)
  ) u_pend (
    .clk      (aclk),
    .rst      (areset),
    .push     (push),
    .push_data(in_ext),
    .pop      (fire),
    .head     (head),
    .full     (pend_full),
    .empty    (pend_empty)
  );

  assign fire        = ~pend_empty & (head.hit | s_rsp_valid) & (~m_res_valid | m_res_ready);
  assign s_rsp_ready = fire & ~head.hit;

  // Scan from the oldest entry down so the newest match overwrites older ones.
  always_comb begin
    match_found = 1'b0;
    match_val   = '0;
    for (int i = HIST_N - 1; i >= 0; i--) begin
      if (hist_vld[i] && hist[i].key == head.key) begin
        match_found = 1'b1;
        match_val   = hist[i].val;
      end
    end
  end

  assign res_val = head.hit ? match_val : s_rsp_val;

  always_ff @(posedge aclk or posedge areset) begin
    if (areset) begin
      m_res_valid <= 1'b0;
      res_q       <= '0;
      hit_cnt     <= '0;
      miss_cnt    <= '0;
      err_nomatch <= 1'b0;
      hist_vld    <= '0;
      for (int i = 0; i < HIST_N; i++) hist[i] <= '0;
    end else if (fire) begin
      m_res_valid <= 1'b1;
      res_q       <= '{key: head.key, val: res_val, last: head.last};
      if (head.hit) begin
        hit_cnt <= hit_cnt + 32'd1;
        if (!match_found) err_nomatch <= 1'b1;
      end else begin
        miss_cnt <= miss_cnt + 32'd1;
      end
      hist[0]  <= '{key: head.key, val: res_val};
      hist_vld <= {hist_vld[HIST_N-2:0], 1'b1};
      for (int i = 1; i < HIST_N; i++) hist[i] <= hist[i-1];
    end else if (m_res_ready) begin
      m_res_valid <= 1'b0;
    end
  end

  assign m_res_key  = res_q.key;
  assign m_res_val  = res_q.val;
  assign m_res_last = res_q.last;
endmodule
